// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider: state encoding and default width.
package div_pkg;

    localparam int DIV_N = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/iter_down_counter.sv
// Loadable down-counter that saturates at zero; sequences the divider's shift/subtract steps.
module iter_down_counter #(
    parameter int cnt_w = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [cnt_w-1:0] load_val,
    input  logic             en,
    output logic [cnt_w-1:0] count,
    output logic             zero
);

    logic [cnt_w-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - cnt_w'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/seq_signed_divider.sv
// Two's-complement signed divider: restoring division on magnitudes, one quotient bit per clock,
// sign fix-up after the last bit, start/done handshake with results held until the next start.
module seq_signed_divider
    import div_pkg::*;
#(
    parameter int n = DIV_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [n-1:0] dividend,
    input  logic [n-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] quotient,
    output logic [n-1:0] remainder,
    output logic         div_by_zero,
    output logic         overflow
);

    localparam int cnt_w = $clog2(n);
    localparam logic [cnt_w-1:0] LAST_STEP = cnt_w'(n - 1);

    state_e       state_q, state_d;
    logic         negQuot_q, negQuot_d;
    logic         negRem_q, negRem_d;
    logic [n-1:0] divMag_q, divMag_d;
    // Partial remainder never reaches |divisor| <= 2^(n-1), so n bits hold it; the
    // (n+1)-th bit only exists transiently in the trial value below.
    logic [n-1:0] rem_q, rem_d;
    logic [n-1:0] quo_q, quo_d;
    logic [n-1:0] quotient_q, quotient_d;
    logic [n-1:0] remainder_q, remainder_d;
    logic         divByZero_q, divByZero_d;
    logic         overflow_q, overflow_d;

    logic             cntLoad, cntEn, cntZero;
    logic [cnt_w-1:0] cntVal;
    logic [n-1:0]     dividendMag, divisorMag;
    logic [n:0]       trial;
    logic             fits;

    iter_down_counter #(.cnt_w(cnt_w)) u_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cntLoad),
        .load_val (LAST_STEP),
        .en       (cntEn),
        .count    (cntVal),
        .zero     (cntZero)
    );

    assign dividendMag = dividend[n-1] ? -dividend : dividend;
    assign divisorMag  = divisor[n-1]  ? -divisor  : divisor;
    assign trial       = {rem_q, quo_q[n-1]};
    assign fits        = (trial >= {1'b0, divMag_q});

    always_comb begin
        state_d     = state_q;
        negQuot_d   = negQuot_q;
        negRem_d    = negRem_q;
        divMag_d    = divMag_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        divByZero_d = divByZero_q;
        overflow_d  = overflow_q;
        cntLoad     = 1'b0;
        cntEn       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    negQuot_d   = dividend[n-1] ^ divisor[n-1];
                    negRem_d    = dividend[n-1];
                    divByZero_d = 1'b0;
                    overflow_d  = 1'b0;
                    if (divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        divByZero_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        divMag_d = divisorMag;
                        rem_d    = '0;
                        quo_d    = dividendMag;
                        cntLoad  = 1'b1;
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                cntEn = !cntZero;
                rem_d = fits ? (n)'(trial - {1'b0, divMag_q}) : trial[n-1:0];
                quo_d = {quo_q[n-2:0], fits};
                if (cntVal == '0) begin
                    state_d = SIGN;
                end
            end
            SIGN: begin
                quotient_d  = negQuot_q ? -quo_q : quo_q;
                remainder_d = negRem_q ? -rem_q : rem_q;
                // A positive result with the top bit set can only be -2^(n-1) / -1.
                overflow_d  = !negQuot_q && quo_q[n-1];
                state_d     = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            negQuot_q   <= 1'b0;
            negRem_q    <= 1'b0;
            divMag_q    <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            divByZero_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            negQuot_q   <= negQuot_d;
            negRem_q    <= negRem_d;
            divMag_q    <= divMag_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            divByZero_q <= divByZero_d;
            overflow_q  <= overflow_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = divByZero_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Self-checking bench for seq_signed_divider: arithmetic reference model compared every cycle,
// plus directed operations checked against hand-computed literals.
module tb_seq_signed_divider;

    localparam int N = 8;

    typedef struct {
        logic [N-1:0] quot;
        logic [N-1:0] rem;
        logic         dbz;
        logic         ovf;
        int           acceptCyc;
        int           doneCycle;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    exp_t         expQ[$];
    exp_t         front;
    logic [N-1:0] holdQuot = '0;
    logic [N-1:0] holdRem  = '0;
    logic         holdDbz  = 1'b0;
    logic         holdOvf  = 1'b0;

    seq_signed_divider #(.n(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference result from plain integer arithmetic: division truncates toward zero and
    // the remainder follows the dividend's sign.
    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t e;
        int   ia;
        int   ib;
        ia = int'($signed(a));
        ib = int'($signed(b));
        e.dbz = 1'b0;
        e.ovf = 1'b0;
        e.acceptCyc = 0;
        e.doneCycle = 0;
        if (ib == 0) begin
            e.quot = '1;
            e.rem  = a;
            e.dbz  = 1'b1;
        end else if (ia == -(2 ** (N - 1)) && ib == -1) begin
            e.quot = N'(ia);
            e.rem  = '0;
            e.ovf  = 1'b1;
        end else begin
            e.quot = N'(ia / ib);
            e.rem  = N'(ia % ib);
        end
        return e;
    endfunction

    // Every cycle: idle outputs hold the last result, in-flight operations keep old results
    // with flags cleared, and the done cycle must land exactly on the predicted edge.
    always @(negedge clk) begin
        if (expQ.size() > 0 && cyc >= expQ[0].acceptCyc) begin
            front = expQ[0];
            if (done) begin
                check("doneCycle", cyc, front.doneCycle);
                check("busyDone", busy, 1'b1);
                check("quotient", quotient, front.quot);
                check("remainder", remainder, front.rem);
                check("divByZero", div_by_zero, front.dbz);
                check("overflow", overflow, front.ovf);
                holdQuot = front.quot;
                holdRem  = front.rem;
                holdDbz  = front.dbz;
                holdOvf  = front.ovf;
                void'(expQ.pop_front());
            end else if (cyc >= front.doneCycle) begin
                check("doneTimeout", done, 1'b1);
                void'(expQ.pop_front());
            end else begin
                check("busyCalc", busy, 1'b1);
                check("flagsCalc", {div_by_zero, overflow}, 2'b00);
                check("holdQuotCalc", quotient, holdQuot);
                check("holdRemCalc", remainder, holdRem);
            end
        end else begin
            check("idleDone", done, 1'b0);
            check("idleBusy", busy, 1'b0);
            check("idleQuot", quotient, holdQuot);
            check("idleRem", remainder, holdRem);
            check("idleFlags", {div_by_zero, overflow}, {holdDbz, holdOvf});
        end
    end

    task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t e;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        e = model(a, b);
        e.acceptCyc = cyc + 1;
        e.doneCycle = (b == '0) ? cyc + 1 : cyc + 10;
        expQ.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone();
        int waited;
        waited = 0;
        while (expQ.size() != 0 && waited < 40) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL waitDone: got pending %0d expected 0 (cycle %0d)", expQ.size(), cyc);
            expQ.delete();
        end
    endtask

    task automatic checkOutput(input string name, input logic [N-1:0] q, input logic [N-1:0] r,
                               input logic dbz, input logic ovf);
        check({name, ".quot"}, quotient, q);
        check({name, ".rem"}, remainder, r);
        check({name, ".dbz"}, div_by_zero, dbz);
        check({name, ".ovf"}, overflow, ovf);
    endtask

    task automatic checkReset(input string name);
        check({name, ".busy"}, busy, 1'b0);
        check({name, ".done"}, done, 1'b0);
        check({name, ".quot"}, quotient, '0);
        check({name, ".rem"}, remainder, '0);
        check({name, ".flags"}, {div_by_zero, overflow}, 2'b00);
    endtask

    task automatic runOp(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] q, input logic [N-1:0] r,
                         input logic dbz, input logic ovf);
        applyStimulus(a, b);
        waitDone();
        checkOutput(name, q, r, dbz, ovf);
    endtask

    initial begin
        rst_n    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #1 rst_n = 1'b0;
        #2 checkReset("reset");
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        runOp("7/2",     8'sd7,    8'sd2,  8'h03, 8'h01, 1'b0, 1'b0);
        runOp("-7/2",   -8'sd7,    8'sd2,  8'hFD, 8'hFF, 1'b0, 1'b0);
        runOp("7/-2",    8'sd7,   -8'sd2,  8'hFD, 8'h01, 1'b0, 1'b0);
        runOp("-7/-2",  -8'sd7,   -8'sd2,  8'h03, 8'hFF, 1'b0, 1'b0);
        runOp("-128/-1", 8'h80,    8'hFF,  8'h80, 8'h00, 1'b0, 1'b1);
        runOp("-128/1",  8'h80,    8'sd1,  8'h80, 8'h00, 1'b0, 1'b0);
        runOp("5/0",     8'sd5,    8'sd0,  8'hFF, 8'h05, 1'b1, 1'b0);
        runOp("127/-128", 8'sd127, 8'h80,  8'h00, 8'h7F, 1'b0, 1'b0);

        // A start with fresh operands mid-calculation must not disturb the running divide.
        applyStimulus(8'sd100, 8'sd7);
        repeat (3) @(negedge clk);
        start    = 1'b1;
        dividend = -8'sd50;
        divisor  = 8'sd3;
        @(negedge clk);
        start = 1'b0;
        waitDone();
        checkOutput("100/7", 8'd14, 8'd2, 1'b0, 1'b0);
        runOp("b2b -100/7", -8'sd100, 8'sd7, 8'hF2, 8'hFE, 1'b0, 1'b0);
        runOp("b2b 0/0",     8'sd0,   8'sd0, 8'hFF, 8'h00, 1'b1, 1'b0);
        runOp("b2b 0/-5",    8'sd0,  -8'sd5, 8'h00, 8'h00, 1'b0, 1'b0);

        // Asynchronous abort mid-operation: outputs clear at once and no done may follow.
        applyStimulus(8'sd100, 8'sd7);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        expQ.delete();
        holdQuot = '0;
        holdRem  = '0;
        holdDbz  = 1'b0;
        holdOvf  = 1'b0;
        #1 checkReset("abort");
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (12) @(negedge clk);
        runOp("9/3", 8'sd9, 8'sd3, 8'h03, 8'h00, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_signed_divider.md
Name: seq_signed_divider

Overview:
- Sequential two's-complement signed divider; the inverse datapath of the team's signed multiplier.
- Restoring shift/subtract on operand magnitudes, one quotient bit per clock; sign fix-up after the last bit.
- start/done handshake; results held stable until the next accepted start.
- An internal down-counting iteration counter sequences the n steps.

Parameters:
- n, 8, operand/result width in bits (n >= 2)
- cnt_w, $clog2(n), iteration counter width (derived; do not override)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- dividend  input  n  signed dividend; sampled at the edge that accepts start
- divisor  input  n  signed divisor; sampled at the edge that accepts start
- busy  output  1  high in every state except IDLE
- done  output  1  single-cycle pulse: results valid
- quotient  output  n  signed quotient, truncated toward zero
- remainder  output  n  signed remainder; takes the dividend's sign (or is 0)
- div_by_zero  output  1  flag: last operation had divisor == 0
- overflow  output  1  flag: last operation was -2^(n-1) / -1

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - busy, done, quotient, remainder, div_by_zero and overflow all = 0.
  - Internal registers cleared.
  - Reset asserted mid-operation aborts the operation; no done pulse is produced.
- States: IDLE, CALC, SIGN, DONE.
- IDLE, start high at edge E0:
  - Latch sign_q = dividend[n-1] ^ divisor[n-1] and sign_r = dividend[n-1].
  - Latch |dividend| and |divisor| as n-bit unsigned values. |-2^(n-1)| = 2^(n-1) fits unsigned.
  - Clear partial remainder r (n+1 bits).
  - Load the quotient shift register q with |dividend|.
  - Load the iteration counter with n-1. Next state = CALC.
  - Clear div_by_zero and overflow.
- IDLE, divisor == 0 at E0:
  - Go directly to DONE.
  - quotient = all ones (-1), remainder = dividend, div_by_zero = 1.
- CALC, each edge:
  - t = {r[n-1:0], q[n-1]}.
  - If t >= |divisor|: r = t - |divisor| and q = {q[n-2:0], 1}; otherwise r = t and q = {q[n-2:0], 0}.
  - Counter decrements. When the counter is 0 at the edge, next state = SIGN. Exactly n CALC edges (E1..En).
- SIGN, edge E(n+1):
  - quotient = sign_q ? -q : q. remainder = sign_r ? -r[n-1:0] : r[n-1:0].
  - overflow = 1 iff sign_q == 0 and q[n-1] == 1. This case occurs only for -2^(n-1) / -1; quotient then wraps to -2^(n-1) and remainder = 0.
  - Next state = DONE.
- DONE:
  - done = 1 for exactly this one cycle (Moore output).
  - Next edge returns to IDLE.
- Latency:
  - Normal case: done visible after E(n+1); busy high from E0 through the DONE cycle.
  - Divide-by-zero case: done visible after E0.
- Result holding: quotient, remainder and both flags hold their values until the next accepted start. At that start, the flags clear and quotient/remainder update only at SIGN or at the DONE shortcut.
- start while busy (CALC/SIGN/DONE) is ignored. start in IDLE immediately after DONE is accepted (back-to-back operations allowed).
- Input changes while busy have no effect.

Decomposition:
- Shared package div_pkg holds:
  - state encoding localparams: IDLE=2'd0, CALC=2'd1, SIGN=2'd2, DONE=2'd3
  - default width constant DIV_N = 8
- One sub-module, iter_down_counter (parameter cnt_w), with ports clk, rst_n, load, load_val, en, count, zero.
  - Loads on load; decrements on en; holds otherwise.
  - No wrap: en at count 0 holds 0.
- All remaining logic (FSM, datapath, sign fix-up) stays in seq_signed_divider.

Test Plan:
- n=8, 7 / 2 -> quotient=3, remainder=1, done pulses one cycle exactly 9 edges after E0, flags 0.
- -7 / 2 -> quotient=-3 (8'hFD), remainder=-1 (8'hFF); 7 / -2 -> quotient=-3, remainder=1; -7 / -2 -> quotient=3, remainder=-1.
- -128 / -1 -> quotient=8'h80, remainder=0, overflow=1; then -128 / 1 -> quotient=-128, remainder=0, overflow=0.
- 5 / 0 -> done one cycle after E0, quotient=8'hFF, remainder=5, div_by_zero=1, busy high for one cycle only.
- Issue 100 / 7, pulse start with new operands during CALC -> ignored, result quotient=14, remainder=2. Then back-to-back start in the IDLE cycle right after DONE is accepted.
- Issue 100 / 7, drop rst_n during CALC -> all outputs 0 immediately (asynchronously), no done. After release, 9 / 3 -> quotient=3, remainder=0.
